// File: rtl/mmss_timer_if.sv
// Control/status bundle between the MM:SS timer and its controller.
// Latency: none (plain wires).
// Backpressure: none; the controller may pulse any control every cycle.
// Ports: start/pause/clear/load/dir/load_val (controller -> timer),
//        nums/tick/done/running (timer -> controller).
interface mmss_timer_if;
  logic        start;
  logic        pause;
  logic        clear;
  logic        dir;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] nums;
  logic        tick;
  logic        done;
  logic        running;

  modport master (
    output start, pause, clear, dir, load, load_val,
    input  nums, tick, done, running
  );

  modport slave (
    input  start, pause, clear, dir, load, load_val,
    output nums, tick, done, running
  );
endinterface

// File: rtl/mmss_timer.sv
// Parametrised BCD minute:second up/down timer with start/pause/clear/load.
// Latency: count changes on the prescaler-wrap edge; nums/tick/done follow one cycle later.
// Backpressure: none; control pulses are accepted every cycle (clear > load > pause > start).
// Ports: clk, rst (async, active-high); bus (slave modport of mmss_timer_if):
//   in  start, pause, clear, dir, load, load_val[15:0]
//   out nums[15:0] {m1,m0,s1,s0}, tick, done, running
module mmss_timer #(
  parameter int CLK_HZ  = 100000000,
  parameter int MAX_MIN = 59,
  parameter bit WRAP    = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  mmss_timer_if.slave  bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  // Elaboration-time split of MAX_MIN into its two BCD digits.
  localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    m1_q, m0_q, s1_q, s0_q;
  logic [3:0]    m1_d, m0_d, s1_d, s0_d;
  logic          tick_int, done_int;
  logic          tick_p_q, done_p_q;
  logic [15:0]   nums_q;
  logic          tick_q, done_q, running_q;

  // Load value after digit saturation and range clamping.
  logic [3:0] lm1, lm0, ls1, ls0;
  // Up-count and down-count successors of the current count.
  logic [3:0] um1, um0, us1, us0;
  logic [3:0] dm1, dm0, ds1, ds0;
  logic       up_term, dn_term;
  logic       at_max, is_zero;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    lm1 = sat9(bus.load_val[15:12]);
    lm0 = sat9(bus.load_val[11:8]);
    ls1 = sat9(bus.load_val[7:4]);
    ls0 = sat9(bus.load_val[3:0]);
    // With every digit <= 9, comparing the packed BCD byte is a numeric compare.
    if ({lm1, lm0} > {MAX_M1, MAX_M0}) begin
      lm1 = MAX_M1;
      lm0 = MAX_M0;
    end
    if (ls1 > 4'd5) begin
      ls1 = 4'd5;
      ls0 = 4'd9;
    end
  end

  assign at_max  = ({m1_q, m0_q} == {MAX_M1, MAX_M0}) && (s1_q == 4'd5) && (s0_q == 4'd9);
  assign is_zero = ({m1_q, m0_q, s1_q, s0_q} == 16'h0000);

  // Up count with BCD carries; terminal handling at MAX_MIN:59.
  always_comb begin
    {um1, um0, us1, us0} = {m1_q, m0_q, s1_q, s0_q};
    up_term = 1'b0;
    if (at_max) begin
      if (WRAP) begin
        {um1, um0, us1, us0} = 16'h0000;
      end else begin
        up_term = 1'b1;
      end
    end else if (s0_q != 4'd9) begin
      us0 = s0_q + 4'd1;
    end else begin
      us0 = 4'd0;
      if (s1_q != 4'd5) begin
        us1 = s1_q + 4'd1;
      end else begin
        us1 = 4'd0;
        if (m0_q != 4'd9) begin
          um0 = m0_q + 4'd1;
        end else begin
          um0 = 4'd0;
          um1 = m1_q + 4'd1;
        end
      end
    end
  end

  // Down count with BCD borrows; reaching (or sitting at) 00:00 is terminal.
  always_comb begin
    {dm1, dm0, ds1, ds0} = {m1_q, m0_q, s1_q, s0_q};
    dn_term = 1'b0;
    if (is_zero) begin
      dn_term = 1'b1;
    end else begin
      if (s0_q != 4'd0) begin
        ds0 = s0_q - 4'd1;
      end else begin
        ds0 = 4'd9;
        if (s1_q != 4'd0) begin
          ds1 = s1_q - 4'd1;
        end else begin
          ds1 = 4'd5;
          if (m0_q != 4'd0) begin
            dm0 = m0_q - 4'd1;
          end else begin
            dm0 = 4'd9;
            dm1 = m1_q - 4'd1;
          end
        end
      end
      dn_term = ({dm1, dm0, ds1, ds0} == 16'h0000);
    end
  end

  // Next-state, prescaler and count update.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    {m1_d, m0_d, s1_d, s0_d} = {m1_q, m0_q, s1_q, s0_q};
    tick_int = 1'b0;
    done_int = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      presc_d = '0;
      {m1_d, m0_d, s1_d, s0_d} = 16'h0000;
    end else if (bus.load) begin
      state_d = IDLE;
      presc_d = '0;
      {m1_d, m0_d, s1_d, s0_d} = {lm1, lm0, ls1, ls0};
    end else begin
      case (state_q)
        IDLE:  if (bus.start) state_d = RUN;
        PAUSE: if (bus.start) state_d = RUN;
        RUN: begin
          if (bus.pause) begin
            // Prescaler holds so the partial second survives the pause.
            state_d = PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d  = '0;
            tick_int = 1'b1;
            if (bus.dir) begin
              {m1_d, m0_d, s1_d, s0_d} = {dm1, dm0, ds1, ds0};
              if (dn_term) begin
                done_int = 1'b1;
                state_d  = DONE;
              end
            end else begin
              {m1_d, m0_d, s1_d, s0_d} = {um1, um0, us1, us0};
              if (up_term) begin
                done_int = 1'b1;
                state_d  = DONE;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes are delayed one stage so they line up with the registered nums copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      m1_q      <= 4'd0;
      m0_q      <= 4'd0;
      s1_q      <= 4'd0;
      s0_q      <= 4'd0;
      tick_p_q  <= 1'b0;
      done_p_q  <= 1'b0;
      nums_q    <= 16'h0000;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      m1_q      <= m1_d;
      m0_q      <= m0_d;
      s1_q      <= s1_d;
      s0_q      <= s0_d;
      tick_p_q  <= tick_int;
      done_p_q  <= done_int;
      nums_q    <= {m1_q, m0_q, s1_q, s0_q};
      tick_q    <= tick_p_q;
      done_q    <= done_p_q;
      running_q <= (state_d == RUN);
    end
  end

  assign bus.nums    = nums_q;
  assign bus.tick    = tick_q;
  assign bus.done    = done_q;
  assign bus.running = running_q;

endmodule
